// File: rtl/spinner_array.sv
// spinner_array: multi-channel wheel emulator turning buttons or analog stick X into wrapping angles
module spinner_array #(
   parameter int NUM_CH        = 4,
   parameter int ANGLE_W       = 6,
   parameter int ACCEL_TICKS   = 8,
   parameter int MAX_STEP_LOG2 = 2,
   parameter int ANALOG_SHIFT  = 4,
   parameter int DEADZONE      = 8
) (
   input  logic                      clk_sys,
   input  logic                      reset_n,
   input  logic                      tick,
   input  logic [NUM_CH-1:0]         btn_left,
   input  logic [NUM_CH-1:0]         btn_right,
   input  logic [NUM_CH-1:0]         analog_en,
   input  logic [NUM_CH*8-1:0]       analog_x,
   output logic [NUM_CH*ANGLE_W-1:0] angle,
   output logic                      update_stb
);
   localparam int CW = $clog2(ACCEL_TICKS + 1);
   localparam int LW = (MAX_STEP_LOG2 > 0) ? $clog2(MAX_STEP_LOG2 + 1) : 1;
   localparam int DW = (ANGLE_W > 8) ? ANGLE_W : 8;
   typedef enum logic {IDLE, HOLD} state_t;
   state_t             st     [NUM_CH];
   state_t             st_nx  [NUM_CH];
   logic               neg    [NUM_CH];
   logic               neg_nx [NUM_CH];
   logic [LW-1:0]      lvl    [NUM_CH];
   logic [LW-1:0]      lvl_nx [NUM_CH];
   logic [CW-1:0]      cnt    [NUM_CH];
   logic [CW-1:0]      cnt_nx [NUM_CH];
   logic [ANGLE_W-1:0] ang    [NUM_CH];
   logic [ANGLE_W-1:0] ang_nx [NUM_CH];
   logic [2:0]         sync;
   logic               tick_rise;
   logic signed [7:0]  x;
   logic [8:0]         ax;
   logic signed [DW-1:0] ash;
   logic [LW-1:0]      nl;
   logic [CW-1:0]      nc;
   logic [ANGLE_W-1:0] stp;

   assign tick_rise = sync[1] & ~sync[2];

   // two-flop tick synchronizer plus edge-history flop, and the update strobe
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync       <= '0;
         update_stb <= 1'b0;
      end else begin
         sync       <= {sync[1:0], tick};
         update_stb <= tick_rise;
      end
   end

   // per-channel FSM state, acceleration state and angle registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            st[c]  <= IDLE;
            neg[c] <= 1'b0;
            lvl[c] <= '0;
            cnt[c] <= '0;
            ang[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            st[c]  <= st_nx[c];
            neg[c] <= neg_nx[c];
            lvl[c] <= lvl_nx[c];
            cnt[c] <= cnt_nx[c];
            ang[c] <= ang_nx[c];
         end
      end
   end

   // next-state: analog delta, or digital step with hold acceleration, only on a tick edge
   always_comb begin
      x   = '0;
      ax  = '0;
      ash = '0;
      nl  = '0;
      nc  = '0;
      stp = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         st_nx[c]  = st[c];
         neg_nx[c] = neg[c];
         lvl_nx[c] = lvl[c];
         cnt_nx[c] = cnt[c];
         ang_nx[c] = ang[c];
         x   = analog_x[8*c +: 8];
         ax  = x[7] ? 9'd0 - {x[7], x} : {x[7], x};
         ash = DW'(x) >>> ANALOG_SHIFT;
         if (ax < 9'(DEADZONE))
            ash = '0;
         if (tick_rise) begin
            if (analog_en[c]) begin
               st_nx[c]  = IDLE;
               lvl_nx[c] = '0;
               cnt_nx[c] = '0;
               ang_nx[c] = ANGLE_W'(DW'(ang[c]) + ash);
            end else if (btn_left[c] == btn_right[c]) begin
               st_nx[c]  = IDLE;
               lvl_nx[c] = '0;
               cnt_nx[c] = '0;
            end else if (st[c] == IDLE || neg[c] != btn_left[c]) begin
               st_nx[c]  = HOLD;
               neg_nx[c] = btn_left[c];
               lvl_nx[c] = '0;
               cnt_nx[c] = CW'(1);
               ang_nx[c] = btn_left[c] ? ang[c] - ANGLE_W'(1) : ang[c] + ANGLE_W'(1);
            end else begin
               nl = lvl[c];
               nc = (cnt[c] == CW'(ACCEL_TICKS)) ? cnt[c] : cnt[c] + CW'(1);
               if (cnt[c] == CW'(ACCEL_TICKS) && lvl[c] < LW'(MAX_STEP_LOG2)) begin
                  nl = lvl[c] + LW'(1);
                  nc = CW'(1);
               end
               stp       = ANGLE_W'(1) << nl;
               lvl_nx[c] = nl;
               cnt_nx[c] = nc;
               ang_nx[c] = btn_left[c] ? ang[c] - stp : ang[c] + stp;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign angle[ANGLE_W*g +: ANGLE_W] = ang[g];
   end
endmodule
